// File: rtl/i2c_temp_pkg.sv
// i2c_temp_pkg: state encoding and ADT7420 constants shared by the I2C temperature reader.
package i2c_temp_pkg;
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, RD_MSB, ACK_MSB, RD_LSB, NACK_LSB, STOP
    } state_t;
    localparam logic [6:0] ADT7420_ADDR       = 7'h4B;
    localparam logic [7:0] ADT7420_REG_T_MSB  = 8'h00;
    localparam logic [7:0] ADT7420_REG_T_LSB  = 8'h01;
    localparam logic [7:0] ADT7420_REG_STATUS = 8'h02;
    localparam logic [7:0] ADT7420_REG_CONFIG = 8'h03;
    localparam logic [7:0] ADT7420_REG_ID     = 8'h0B;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-SCL-period tick; held at phase zero while disabled so every
// transaction starts on a full quarter.
module i2c_tick_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int SCL_HZ = 100_000
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int DIV = CLK_HZ / (4 * SCL_HZ);
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/i2c_temp_reader.sv
// i2c_temp_reader: periodically reads the two ADT7420 temperature bytes over I2C
// and holds the last good reading.
module i2c_temp_reader
    import i2c_temp_pkg::*;
#(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         SCL_HZ      = 100_000,
    parameter int         POLL_CYCLES = 25_000_000,
    parameter logic [6:0] DEV_ADDR    = ADT7420_ADDR
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    output logic        SCL,
    inout  wire         SDA,
    output logic [15:0] temp_data,
    output logic        data_valid,
    output logic        nack_err
);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    state_t        state;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    msb;
    logic [PW-1:0] poll_cnt;
    logic          pending;
    logic          sda_oe;
    logic          sda_s1;
    logic          sda_s2;
    logic          tick;
    logic          expire;

    assign SDA    = sda_oe ? 1'b0 : 1'bz;
    assign expire = poll_cnt == PW'(POLL_CYCLES - 1);

    i2c_tick_gen #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ)) u_tick (
        .clk_100MHz(clk_100MHz),
        .rst_n     (rst_n),
        .en        (state != IDLE),
        .tick      (tick)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)
            {sda_s2, sda_s1} <= 2'b11;
        else
            {sda_s2, sda_s1} <= {sda_s1, SDA};
    end

    // q is the quarter within the current bit; SCL is high during quarters 1 and 2.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            q          <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            msb        <= '0;
            poll_cnt   <= '0;
            pending    <= 1'b0;
            SCL        <= 1'b1;
            sda_oe     <= 1'b0;
            temp_data  <= '0;
            data_valid <= 1'b0;
            nack_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            poll_cnt   <= expire ? '0 : poll_cnt + 1'b1;
            pending    <= (state != IDLE) && (pending || expire);
            if (state == IDLE) begin
                SCL     <= 1'b1;
                sda_oe  <= 1'b0;
                q       <= '0;
                bit_cnt <= '0;
                if (expire || pending) begin
                    state  <= START;
                    sda_oe <= 1'b1;
                    shreg  <= {DEV_ADDR, 1'b1};
                end
            end else if (tick) begin
                q <= q + 1'b1;
                if (q == 2'd0)
                    SCL <= 1'b1;
                if (q == 2'd2) begin
                    SCL <= (state == STOP);
                    if (state == STOP)
                        sda_oe <= 1'b0;
                    if (state inside {ADDR_ACK, RD_MSB, RD_LSB})
                        shreg <= {shreg[6:0], sda_s2};
                end
                if (q == 2'd3) begin
                    if (state inside {ADDR, RD_MSB, RD_LSB})
                        bit_cnt <= bit_cnt + 1'b1;
                    case (state)
                        START: begin
                            state  <= ADDR;
                            sda_oe <= ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                        ADDR: begin
                            state  <= (bit_cnt == 3'd7) ? ADDR_ACK : ADDR;
                            sda_oe <= (bit_cnt == 3'd7) ? 1'b0 : ~shreg[7];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                        ADDR_ACK: begin
                            state    <= shreg[0] ? STOP : RD_MSB;
                            sda_oe   <= shreg[0];
                            nack_err <= nack_err | shreg[0];
                        end
                        RD_MSB: if (bit_cnt == 3'd7) begin
                            state  <= ACK_MSB;
                            msb    <= shreg;
                            sda_oe <= 1'b1;
                        end
                        ACK_MSB: begin
                            state  <= RD_LSB;
                            sda_oe <= 1'b0;
                        end
                        RD_LSB: if (bit_cnt == 3'd7)
                            state <= NACK_LSB;
                        NACK_LSB: begin
                            state      <= STOP;
                            sda_oe     <= 1'b1;
                            temp_data  <= {msb, shreg};
                            data_valid <= 1'b1;
                            nack_err   <= 1'b0;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_temp_reader.sv
// tb_i2c_temp_reader: ADT7420 slave model plus a scoreboard of expected readings.
module tb_i2c_temp_reader;
    localparam int POLL     = 5000;
    localparam int BIT_CLKS = 1000;

    typedef struct {
        bit         ack;
        logic [7:0] msb;
        logic [7:0] lsb;
    } sl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    wire         sda;
    logic [15:0] temp_data;
    logic        data_valid;
    logic        nack_err;

    logic        s_low = 1'b0;
    logic        s_busy = 1'b0;
    logic        scl_q = 1'b1;
    logic        sda_q = 1'b1;
    logic        m_ack = 1'bx;
    logic        m_nack = 1'bx;
    int          s_n = 0;
    int          n_start = 0;
    int          n_stop = 0;
    int          stop_bits = 0;
    int          dv_cnt = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          last_rise = 0;
    int          per_min = 0;
    int          per_max = 0;
    int          start_cyc[8];
    int          n_chk = 0;
    int          n_err = 0;
    sl_t         cur;
    sl_t         sl_q[$];
    logic [15:0] exp_q[$];

    pullup (sda);
    assign sda = s_low ? 1'b0 : 1'bz;

    i2c_temp_reader #(.POLL_CYCLES(POLL)) dut (
        .clk_100MHz(clk),
        .rst_n     (rst_n),
        .SCL       (scl),
        .SDA       (sda),
        .temp_data (temp_data),
        .data_valid(data_valid),
        .nack_err  (nack_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Bit index n counts SCL rises since START: 8 is the address ACK, 9-16 MSB, 18-25 LSB.
    function automatic logic drive(input int n);
        if (!cur.ack)
            return 1'b0;
        if (n == 8)
            return 1'b1;
        if (n >= 9 && n <= 16)
            return !cur.msb[16-n];
        if (n >= 18 && n <= 25)
            return !cur.lsb[25-n];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            s_busy = 1'b0;
            s_low  = 1'b0;
        end else begin
            if (data_valid) begin
                dv_cnt++;
                if (exp_q.size() == 0)
                    check("dv_unexpected", 1, 0);
                else
                    check("temp_data_sb", {16'h0, temp_data}, {16'h0, exp_q.pop_front()});
            end
            if (scl_q && scl && sda_q && !sda) begin
                if (n_start < 8)
                    start_cyc[n_start] = cyc;
                n_start++;
                s_busy  = 1'b1;
                s_n     = 0;
                s_low   = 1'b0;
                per_min = 32'h7fffffff;
                per_max = 0;
                if (sl_q.size() != 0)
                    cur = sl_q.pop_front();
                else
                    cur = '{ack: 1'b0, msb: 8'h00, lsb: 8'h00};
            end else if (scl_q && scl && !sda_q && sda) begin
                if (s_busy) begin
                    n_stop++;
                    stop_bits = s_n;
                end
                s_busy = 1'b0;
                s_low  = 1'b0;
            end else if (s_busy && !scl_q && scl) begin
                if (s_n > 0) begin
                    if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                    if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                end
                last_rise = cyc;
                if (s_n == 17) m_ack = sda;
                if (s_n == 26) m_nack = sda;
                s_n++;
            end else if (s_busy && scl_q && !scl) begin
                s_low = drive(s_n);
            end
        end
        scl_q = scl;
        sda_q = sda;
    end

    task automatic wait_stops(input int n);
        int t = 0;
        while (n_stop < n && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("stop_seen", n_stop, n);
    endtask

    task automatic wait_starts(input int n);
        int t = 0;
        while (n_start < n && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", n_start, n);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        sl_q.push_back('{ack: 1'b1, msb: 8'h0C, lsb: 8'h80});
        exp_q.push_back(16'h0C80);
        sl_q.push_back('{ack: 1'b1, msb: 8'hFF, lsb: 8'h80});
        exp_q.push_back(16'hFF80);
        sl_q.push_back('{ack: 1'b0, msb: 8'h00, lsb: 8'h00});
        // Interrupted by reset during the MSB, so no reading is expected from it.
        sl_q.push_back('{ack: 1'b1, msb: 8'hFF, lsb: 8'h80});
        repeat (4) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_temp", temp_data, 0);
        check("rst_dv", data_valid, 0);
        check("rst_nack", nack_err, 0);
        rst_n   = 1'b1;
        rel_cyc = cyc;

        wait_stops(1);
        check("first_start_delay", start_cyc[0] - rel_cyc, POLL);
        check("good1_temp", temp_data, 16'h0C80);
        check("good1_nack", nack_err, 0);
        check("good1_dv_cnt", dv_cnt, 1);
        check("scl_period_min", per_min, BIT_CLKS);
        check("scl_period_max", per_max, BIT_CLKS);
        check("master_ack_msb", m_ack, 0);
        check("master_nack_lsb", m_nack, 1);
        check("good1_bits", stop_bits, 28);

        // A read lasts 29 bit times, longer than the poll period, so the pending
        // expiry starts the next read on the first cycle back in IDLE.
        m_ack  = 1'bx;
        m_nack = 1'bx;
        wait_stops(2);
        check("b2b_interval", start_cyc[1] - start_cyc[0], 29 * BIT_CLKS + 1);
        check("good2_temp", temp_data, 16'hFF80);
        check("good2_dv_cnt", dv_cnt, 2);
        check("good2_master_ack", m_ack, 0);
        check("good2_master_nack", m_nack, 1);

        wait_stops(3);
        check("nack_interval", start_cyc[2] - start_cyc[1], 29 * BIT_CLKS + 1);
        check("nack_err_set", nack_err, 1);
        check("nack_temp_kept", temp_data, 16'hFF80);
        check("nack_no_dv", dv_cnt, 2);
        check("nack_bits", stop_bits, 10);

        t = 0;
        while (!(n_start >= 4 && s_n >= 10) && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("rd_msb_reached", (n_start >= 4 && s_n >= 10), 1);
        check("after_nack_interval", start_cyc[3] - start_cyc[2], 11 * BIT_CLKS + 1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_temp", temp_data, 0);
        check("midrst_nack", nack_err, 0);
        check("midrst_dv", data_valid, 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_starts(5);
        check("restart_delay", start_cyc[4] - rel_cyc, POLL);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
